// File: rtl/matrix_mac_sequencer_if.sv
// Bundle of the host handshake, operand memory reads, MAC control and the
// result memory write port of the matrix MAC sequencer.
interface matrix_mac_sequencer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int ADDR_WIDTH = 8
);
    // host handshake
    logic                  start;
    logic                  abort;
    logic                  busy;
    logic                  done;
    // operand memory A
    logic                  a_rd_en;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_data;
    // operand memory B
    logic                  b_rd_en;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] b_data;
    // MAC unit
    logic                  mac_enable;
    logic                  mac_clear;
    logic [DATA_WIDTH-1:0] mac_a;
    logic [DATA_WIDTH-1:0] mac_b;
    logic [ACC_WIDTH-1:0]  mac_result;
    // result memory C
    logic                  c_wr_en;
    logic [ADDR_WIDTH-1:0] c_addr;
    logic [ACC_WIDTH-1:0]  c_data;

    // sequencer side
    modport master (
        input  start, abort, a_data, b_data, mac_result,
        output busy, done, a_rd_en, a_addr, b_rd_en, b_addr,
               mac_enable, mac_clear, mac_a, mac_b, c_wr_en, c_addr, c_data
    );

    // environment side: host, memories and MAC
    modport slave (
        output start, abort, a_data, b_data, mac_result,
        input  busy, done, a_rd_en, a_addr, b_rd_en, b_addr,
               mac_enable, mac_clear, mac_a, mac_b, c_wr_en, c_addr, c_data
    );
endinterface

// File: rtl/matrix_mac_sequencer.sv
// Sequencer computing C = A x B for DIM x DIM matrices on a single-accumulator
// MAC. For each output element: clear the MAC, read DIM operand pairs, let the
// last products settle, then write the dot product to C.
module matrix_mac_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int DIM        = 4,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    matrix_mac_sequencer_if.master bus
);

    localparam int CW = (DIM > 1) ? $clog2(DIM) : 1;
    localparam logic [CW-1:0] IDX_LAST = CW'(DIM - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN1,
        S_DRAIN2,
        S_WRITE,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  i_q, i_d;
    logic [CW-1:0]  j_q, j_d;
    logic [CW-1:0]  k_q, k_d;
    // operand data from the memories is valid the cycle after a FEED read
    logic           valid_q, valid_d;

    logic                  busy_o;
    logic                  done_o;
    logic                  rd_en_o;
    logic [ADDR_WIDTH-1:0] a_addr_o;
    logic [ADDR_WIDTH-1:0] b_addr_o;
    logic                  mac_clear_o;
    logic                  c_wr_en_o;
    logic [ADDR_WIDTH-1:0] c_addr_o;
    logic [ACC_WIDTH-1:0]  c_data_o;

    // state, index counters and operand-valid register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            valid_q <= valid_d;
        end
    end

    // next-state, counter advance and strobe decode
    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        k_d         = k_q;
        valid_d     = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        rd_en_o     = 1'b0;
        a_addr_o    = '0;
        b_addr_o    = '0;
        mac_clear_o = 1'b0;
        c_wr_en_o   = 1'b0;
        c_addr_o    = '0;
        c_data_o    = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_CLEAR;
                    i_d     = '0;
                    j_d     = '0;
                end
            end
            S_CLEAR: begin
                busy_o      = 1'b1;
                mac_clear_o = 1'b1;
                k_d         = '0;
                state_d     = S_FEED;
            end
            S_FEED: begin
                busy_o   = 1'b1;
                rd_en_o  = 1'b1;
                valid_d  = 1'b1;
                // index products are truncated to the address width
                a_addr_o = ADDR_WIDTH'(int'(i_q) * DIM + int'(k_q));
                b_addr_o = ADDR_WIDTH'(int'(k_q) * DIM + int'(j_q));
                if (k_q == IDX_LAST) begin
                    k_d     = '0;
                    state_d = S_DRAIN1;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_DRAIN1: begin
                busy_o  = 1'b1;
                state_d = S_DRAIN2;
            end
            S_DRAIN2: begin
                busy_o  = 1'b1;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                busy_o    = 1'b1;
                c_wr_en_o = 1'b1;
                c_addr_o  = ADDR_WIDTH'(int'(i_q) * DIM + int'(j_q));
                c_data_o  = bus.mac_result;
                state_d   = S_CLEAR;
                if (j_q == IDX_LAST) begin
                    j_d = '0;
                    if (i_q == IDX_LAST) begin
                        i_d     = '0;
                        state_d = S_DONE;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // abort cancels from any busy state; a coinciding WRITE still
        // completes because its strobe is already decoded this cycle
        if (busy_o && bus.abort) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
        end
    end

    assign bus.busy       = busy_o;
    assign bus.done       = done_o;
    assign bus.a_rd_en    = rd_en_o;
    assign bus.b_rd_en    = rd_en_o;
    assign bus.a_addr     = a_addr_o;
    assign bus.b_addr     = b_addr_o;
    assign bus.mac_clear  = mac_clear_o;
    assign bus.mac_enable = valid_q;
    // operands are gated so the MAC inputs idle at zero
    assign bus.mac_a      = valid_q ? bus.a_data : '0;
    assign bus.mac_b      = valid_q ? bus.b_data : '0;
    assign bus.c_wr_en    = c_wr_en_o;
    assign bus.c_addr     = c_addr_o;
    assign bus.c_data     = c_data_o;

endmodule
